// File: rtl/cpu_pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// cpu_pipe_ctrl_if
// Signal bundle between the 5-stage pipeline datapath and its hazard
// controller.
//   master : pipeline side. Drives the ID/EX/memory/CP0 status and receives
//            the stall/bubble controls and the MUL/DIV status.
//   slave  : controller side (cpu_pipe_ctrl).
// Signals:
//   id_re1/id_re2, id_raddr1/id_raddr2 : ID operand reads
//   ex_valid, ex_is_load, ex_waddr     : EX instruction description
//   ex_md_op                           : EX op class (0 none, 1 mul, 2 div, 3 = none)
//   imem_busy, dmem_busy               : memory wait states
//   flush                              : exception/ERET redirect
//   stall_*                            : hold PC / pipeline registers
//   bubble_*                           : load NOP into pipeline registers
//   md_busy, md_done                   : MUL/DIV occupancy status
// ---------------------------------------------------------------------------
interface cpu_pipe_ctrl_if;
    logic       id_re1;
    logic       id_re2;
    logic [4:0] id_raddr1;
    logic [4:0] id_raddr2;
    logic       ex_valid;
    logic       ex_is_load;
    logic [4:0] ex_waddr;
    logic [1:0] ex_md_op;
    logic       imem_busy;
    logic       dmem_busy;
    logic       flush;
    logic       stall_pc;
    logic       stall_if_id;
    logic       stall_id_ex;
    logic       stall_ex_mem;
    logic       bubble_if_id;
    logic       bubble_id_ex;
    logic       bubble_ex_mem;
    logic       bubble_mem_wb;
    logic       md_busy;
    logic       md_done;

    modport master (
        output id_re1, id_re2, id_raddr1, id_raddr2,
        output ex_valid, ex_is_load, ex_waddr, ex_md_op,
        output imem_busy, dmem_busy, flush,
        input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
        input  bubble_if_id, bubble_id_ex, bubble_ex_mem, bubble_mem_wb,
        input  md_busy, md_done
    );

    modport slave (
        input  id_re1, id_re2, id_raddr1, id_raddr2,
        input  ex_valid, ex_is_load, ex_waddr, ex_md_op,
        input  imem_busy, dmem_busy, flush,
        output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
        output bubble_if_id, bubble_id_ex, bubble_ex_mem, bubble_mem_wb,
        output md_busy, md_done
    );
endinterface

// File: rtl/cpu_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_pipe_ctrl
// Central hazard controller for a 5-stage MIPS pipeline. Every cycle it
// decides which pipeline registers hold and which receive a bubble, covering
// exception flush, data-memory wait, multi-cycle MUL/DIV occupancy of EX,
// load-use hazards and instruction-memory wait (in that priority order).
// The only state is the MUL/DIV occupancy FSM and its cycle counter; all
// outputs are combinational from that state and the current inputs.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous reset, active low
//   bus : cpu_pipe_ctrl_if.slave (pipeline status in, stall/bubble out)
// Parameters:
//   MUL_CYCLES : EX cycles a multiply occupies (>=1)
//   DIV_CYCLES : EX cycles a divide occupies (>=1)
//   CNT_W      : counter width, holds max(MUL_CYCLES,DIV_CYCLES)-1
// ---------------------------------------------------------------------------
module cpu_pipe_ctrl #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic              clk,
    input  logic              rst,
    cpu_pipe_ctrl_if.slave    bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Counter preload: the first EX cycle is spent in IDLE and the last one
    // is the cnt==0 cycle in BUSY, hence N-2.
    localparam logic [CNT_W-1:0] MUL_LOAD =
        (MUL_CYCLES >= 2) ? CNT_W'(MUL_CYCLES - 2) : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] DIV_LOAD =
        (DIV_CYCLES >= 2) ? CNT_W'(DIV_CYCLES - 2) : {CNT_W{1'b0}};
    localparam logic MUL_SINGLE = (MUL_CYCLES == 1);
    localparam logic DIV_SINGLE = (DIV_CYCLES == 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    logic             md_start_s;
    logic             md_single_s;
    logic [CNT_W-1:0] md_load_s;
    logic             cnt_zero_s;
    logic             md_hold_s;
    logic             load_use_s;

    // Decode the EX op class into start/latency information (op 3 = none).
    always_comb begin
        md_start_s  = 1'b0;
        md_single_s = 1'b0;
        md_load_s   = {CNT_W{1'b0}};
        case (bus.ex_md_op)
            2'd1: begin
                md_start_s  = 1'b1;
                md_single_s = MUL_SINGLE;
                md_load_s   = MUL_LOAD;
            end
            2'd2: begin
                md_start_s  = 1'b1;
                md_single_s = DIV_SINGLE;
                md_load_s   = DIV_LOAD;
            end
            default: begin
                md_start_s  = 1'b0;
                md_single_s = 1'b0;
                md_load_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Hazard conditions shared by the next-state and output logic.
    always_comb begin
        cnt_zero_s = (cnt_r == {CNT_W{1'b0}});
        if (state_r == ST_BUSY) begin
            md_hold_s = !cnt_zero_s;
        end else begin
            md_hold_s = md_start_s && !md_single_s;
        end
        load_use_s = bus.ex_valid && bus.ex_is_load && (bus.ex_waddr != 5'd0) &&
                     ((bus.id_re1 && (bus.id_raddr1 == bus.ex_waddr)) ||
                      (bus.id_re2 && (bus.id_raddr2 == bus.ex_waddr)));
    end

    // FSM state and counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // FSM next state: flush aborts, dmem wait freezes, otherwise count down.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (bus.flush) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (bus.dmem_busy) begin
            state_nxt_s = state_r;
            cnt_nxt_s   = cnt_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (md_start_s && !md_single_s) begin
                        state_nxt_s = ST_BUSY;
                        cnt_nxt_s   = md_load_s;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = cnt_r;
                    end
                end
                ST_BUSY: begin
                    // Only decremented while nonzero, so it never wraps.
                    if (!cnt_zero_s) begin
                        state_nxt_s = ST_BUSY;
                        cnt_nxt_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Stall/bubble outputs by priority; no register is both stalled and bubbled.
    always_comb begin
        bus.stall_pc      = 1'b0;
        bus.stall_if_id   = 1'b0;
        bus.stall_id_ex   = 1'b0;
        bus.stall_ex_mem  = 1'b0;
        bus.bubble_if_id  = 1'b0;
        bus.bubble_id_ex  = 1'b0;
        bus.bubble_ex_mem = 1'b0;
        bus.bubble_mem_wb = 1'b0;
        bus.md_busy       = (state_r == ST_BUSY);
        bus.md_done       = 1'b0;
        if (bus.flush) begin
            bus.bubble_if_id  = 1'b1;
            bus.bubble_id_ex  = 1'b1;
            bus.bubble_ex_mem = 1'b1;
            bus.bubble_mem_wb = 1'b1;
        end else if (bus.dmem_busy) begin
            bus.stall_pc      = 1'b1;
            bus.stall_if_id   = 1'b1;
            bus.stall_id_ex   = 1'b1;
            bus.stall_ex_mem  = 1'b1;
            bus.bubble_mem_wb = 1'b1;
        end else begin
            // Last EX cycle of a MUL/DIV: release the hold and flag the result.
            if (state_r == ST_BUSY) begin
                bus.md_done = cnt_zero_s;
            end else begin
                bus.md_done = md_start_s && md_single_s;
            end
            if (md_hold_s) begin
                bus.stall_pc      = 1'b1;
                bus.stall_if_id   = 1'b1;
                bus.stall_id_ex   = 1'b1;
                bus.bubble_ex_mem = 1'b1;
            end else if (load_use_s) begin
                bus.stall_pc     = 1'b1;
                bus.stall_if_id  = 1'b1;
                bus.bubble_id_ex = 1'b1;
            end else if (bus.imem_busy) begin
                bus.stall_pc     = 1'b1;
                bus.bubble_if_id = 1'b1;
            end else begin
                bus.stall_pc = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_pipe_ctrl
// Directed scenarios followed by randomized traffic for cpu_pipe_ctrl.
// Expected outputs come from a reference model that tracks "remaining EX
// cycles of the current MUL/DIV" and applies the output priority rules.
// Output vector order: {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
//   bubble_if_id, bubble_id_ex, bubble_ex_mem, bubble_mem_wb, md_busy, md_done}
// ---------------------------------------------------------------------------
module tb_cpu_pipe_ctrl;

    localparam int MUL = 2;
    localparam int DIV = 32;

    logic clk;
    logic rst;
    cpu_pipe_ctrl_if bus();

    cpu_pipe_ctrl #(.MUL_CYCLES(MUL), .DIV_CYCLES(DIV), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model state: an op is in progress with m_rem EX cycles left.
    bit m_active = 1'b0;
    int m_rem    = 0;

    logic [9:0] obs;
    logic [9:0] last_obs;
    assign obs = {bus.stall_pc, bus.stall_if_id, bus.stall_id_ex, bus.stall_ex_mem,
                  bus.bubble_if_id, bus.bubble_id_ex, bus.bubble_ex_mem, bus.bubble_mem_wb,
                  bus.md_busy, bus.md_done};

    function automatic bit m_starting();
        return (bus.ex_md_op == 2'd1) || (bus.ex_md_op == 2'd2);
    endfunction

    function automatic int m_remaining();
        if (m_active) return m_rem;
        return (bus.ex_md_op == 2'd1) ? MUL : DIV;
    endfunction

    function automatic logic [9:0] model_exp();
        logic [9:0] v;
        bit occ, last, hold, lu;
        v    = 10'b0;
        occ  = m_active || m_starting();
        last = occ && (m_remaining() == 1);
        hold = occ && !last;
        lu   = bus.ex_valid && bus.ex_is_load && (bus.ex_waddr != 5'd0) &&
               ((bus.id_re1 && bus.id_raddr1 == bus.ex_waddr) ||
                (bus.id_re2 && bus.id_raddr2 == bus.ex_waddr));
        if (bus.flush)          v[5:2] = 4'b1111;
        else if (bus.dmem_busy) begin v[9:6] = 4'b1111; v[2] = 1'b1; end
        else if (hold)          begin v[9:7] = 3'b111;  v[3] = 1'b1; end
        else if (lu)            begin v[9:8] = 2'b11;   v[4] = 1'b1; end
        else if (bus.imem_busy) begin v[9] = 1'b1;      v[5] = 1'b1; end
        v[1] = m_active;
        v[0] = occ && last && !bus.flush && !bus.dmem_busy;
        return v;
    endfunction

    task automatic model_update();
        bit occ;
        int r;
        occ = m_active || m_starting();
        r   = m_remaining();
        if (bus.flush) begin
            m_active = 1'b0;
        end else if (!bus.dmem_busy && occ) begin
            if (r == 1) m_active = 1'b0;
            else begin m_active = 1'b1; m_rem = r - 1; end
        end
    endtask

    task automatic chk(input string tag, input logic [9:0] o, input logic [9:0] e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, o, e);
    endtask

    task automatic chk_int(input string tag, input int o, input int e);
        total++;
        assert (o == e) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    endtask

    // One cycle: check at negedge against the model, then advance at posedge.
    task automatic step(input string tag);
        @(negedge clk);
        last_obs = obs;
        chk(tag, obs, model_exp());
        @(posedge clk);
        if (rst) model_update();
        else begin m_active = 1'b0; m_rem = 0; end
        #1;
    endtask

    task automatic clr_inputs();
        bus.id_re1 = 1'b0; bus.id_re2 = 1'b0;
        bus.id_raddr1 = 5'd0; bus.id_raddr2 = 5'd0;
        bus.ex_valid = 1'b0; bus.ex_is_load = 1'b0;
        bus.ex_waddr = 5'd0; bus.ex_md_op = 2'd0;
        bus.imem_busy = 1'b0; bus.dmem_busy = 1'b0; bus.flush = 1'b0;
    endtask

    initial begin
        int done_cyc;
        int stall_cyc;
        rst = 1'b0;
        clr_inputs();

        // Reset held for 3 cycles, then released.
        for (int i = 0; i < 3; i++) begin
            step("reset_model");
            chk("reset_zero", last_obs, 10'b0);
        end
        rst = 1'b1;
        step("post_reset");
        chk("post_reset_zero", last_obs, 10'b0);

        // Load-use on operand 2: one-cycle stall.
        bus.ex_valid = 1'b1; bus.ex_is_load = 1'b1; bus.ex_waddr = 5'd5;
        bus.id_re2 = 1'b1; bus.id_raddr2 = 5'd5;
        step("load_use");
        chk("load_use_explicit", last_obs, 10'b1100010000);
        clr_inputs();
        step("load_use_clear");
        chk("load_use_gone", last_obs, 10'b0);
        bus.ex_valid = 1'b1; bus.ex_is_load = 1'b1; bus.ex_waddr = 5'd0;
        bus.id_re2 = 1'b1; bus.id_raddr2 = 5'd0;
        step("load_use_r0");
        chk("load_use_r0_explicit", last_obs, 10'b0);
        clr_inputs();

        // Plain divide: 31 hold cycles, md_done on cycle 32.
        bus.ex_md_op = 2'd2;
        done_cyc = 0; stall_cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            step("div_plain");
            if (last_obs[7]) stall_cyc++;
            if (last_obs[0]) begin done_cyc = c; break; end
        end
        bus.ex_md_op = 2'd0;
        chk_int("div_done_cycle", done_cyc, 32);
        chk_int("div_stall_cycles", stall_cyc, 31);
        step("div_after");

        // Divide with dmem wait on cycles 10..12: done slips by 3.
        bus.ex_md_op = 2'd2;
        done_cyc = 0;
        for (int c = 1; c <= 45; c++) begin
            bus.dmem_busy = (c >= 10 && c <= 12);
            step("div_dmem");
            if (c == 11) chk("div_dmem_explicit", last_obs, 10'b1111000110);
            if (last_obs[0]) begin done_cyc = c; break; end
        end
        clr_inputs();
        chk_int("div_dmem_done_cycle", done_cyc, 35);
        step("div_dmem_after");

        // Flush at cycle 10 of a divide.
        bus.ex_md_op = 2'd2;
        for (int c = 1; c <= 9; c++) step("div_pre_flush");
        bus.flush = 1'b1;
        step("div_flush");
        chk("flush_explicit", last_obs, 10'b0000111110);
        clr_inputs();
        step("after_flush");
        chk("after_flush_explicit", last_obs, 10'b0);

        // Async reset in the middle of a multiply.
        bus.ex_md_op = 2'd1;
        step("mul_start");
        chk("mul_start_explicit", last_obs, 10'b1110001000);
        total++;
        assert (bus.md_busy === 1'b1) passed++;
        else $error("FAIL mul_busy observed=%b expected=1", bus.md_busy);
        rst = 1'b0;
        #1;
        total++;
        assert (bus.md_busy === 1'b0) passed++;
        else $error("FAIL async_rst_busy observed=%b expected=0", bus.md_busy);
        m_active = 1'b0;
        clr_inputs();
        step("in_reset");
        rst = 1'b1;

        // imem wait together with load-use: load-use wins.
        bus.imem_busy = 1'b1;
        bus.ex_valid = 1'b1; bus.ex_is_load = 1'b1; bus.ex_waddr = 5'd9;
        bus.id_re1 = 1'b1; bus.id_raddr1 = 5'd9;
        step("prio_lu_imem");
        chk("prio_explicit", last_obs, 10'b1100010000);
        clr_inputs();
        bus.imem_busy = 1'b1;
        step("imem_only");
        chk("imem_explicit", last_obs, 10'b1000100000);
        clr_inputs();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bus.flush      = ($urandom % 40) == 0;
            bus.dmem_busy  = ($urandom % 6) == 0;
            bus.imem_busy  = ($urandom % 4) == 0;
            bus.ex_md_op   = (($urandom % 8) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            bus.ex_valid   = 1'($urandom);
            bus.ex_is_load = 1'($urandom);
            bus.ex_waddr   = 5'($urandom % 4);
            bus.id_re1     = 1'($urandom);
            bus.id_re2     = 1'($urandom);
            bus.id_raddr1  = 5'($urandom % 4);
            bus.id_raddr2  = 5'($urandom % 4);
            step("random");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
